// File: rtl/multicycle_controller.sv
// Multicycle RV32I controller: sequences fetch/decode/exec/mem/muldiv/wb,
// handshakes with instruction memory, data memory and an iterative mul/div
// unit, and traps on illegal instructions and memory timeouts.
module multicycle_controller #(
  parameter bit ENABLE_M    = 1'b1,
  parameter int MEM_TIMEOUT = 15,
  parameter bit TRAP_HALT   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  output logic        fetchReq,
  input  logic        fetchAck,
  input  logic        memAck,
  input  logic        aluFlag,
  input  logic        muldivDone,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        regWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic        muldivStart,
  output logic        memtoReg,
  output logic        pc4toReg,
  output logic        pcImmtoReg,
  output logic        extendSign,
  output logic [1:0]  Alu2opn,
  output logic [1:0]  jumpSel,
  output logic [1:0]  WL,
  output logic [3:0]  aluSelect,
  output logic [2:0]  InstFormat,
  output logic        retired,
  output logic        trapValid,
  output logic [1:0]  trapCause,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_MULDIV = 3'd5,
    S_WB     = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_R     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;

  localparam logic [7:0] CNT_LIM = 8'(MEM_TIMEOUT - 1);

  state_t     st;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic [7:0] cnt;
  logic [1:0] cause;
  logic       md_first;

  logic is_jal, is_jalr, is_br, is_load, is_store, is_mop, illegal;

  // Instruction class and legality from the latched fields
  always_comb begin
    is_jal   = (opcode == OP_JAL);
    is_jalr  = (opcode == OP_JALR);
    is_br    = (opcode == OP_BR);
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_STORE);
    is_mop   = (opcode == OP_R) && (func7 == F7_M) && ENABLE_M;
    illegal  = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: illegal = 1'b0;
      OP_BR:    illegal = (func3[2:1] == 2'b01);
      OP_LOAD:  illegal = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
      OP_STORE: illegal = (func3 >= 3'b011);
      OP_IMM:   illegal = ((func3 == 3'b001) || (func3 == 3'b101)) &&
                          !((func7 == F7_BASE) || (func7 == F7_ALT));
      OP_R:     illegal = !((func7 == F7_BASE) || (func7 == F7_ALT) ||
                            ((func7 == F7_M) && ENABLE_M)) ||
                          ((func7 == F7_ALT) && !((func3 == 3'b000) || (func3 == 3'b101)));
      default:  illegal = 1'b1;
    endcase
  end

  // Main sequencer: state, latched instruction fields, timeout counter, trap cause
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      opcode   <= OP_IMM;
      func3    <= 3'b000;
      func7    <= F7_BASE;
      cnt      <= 8'd0;
      cause    <= 2'd0;
      md_first <= 1'b0;
    end else begin
      md_first <= 1'b0;
      case (st)
        S_IDLE: begin
          st  <= S_FETCH;
          cnt <= 8'd0;
        end
        S_FETCH: begin
          if (fetchAck) begin
            opcode <= instr[6:0];
            func3  <= instr[14:12];
            func7  <= instr[31:25];
            st     <= S_DECODE;
          end else if (cnt == CNT_LIM) begin
            st    <= S_TRAP;
            cause <= 2'd2;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DECODE: begin
          if (illegal) begin
            st    <= S_TRAP;
            cause <= 2'd1;
          end else if (is_mop) begin
            st       <= S_MULDIV;
            md_first <= 1'b1;
          end else begin
            st <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_load || is_store) begin
            st  <= S_MEM;
            cnt <= 8'd0;
          end else begin
            st <= S_WB;
          end
        end
        S_MEM: begin
          if (memAck) begin
            st <= S_WB;
          end else if (cnt == CNT_LIM) begin
            st    <= S_TRAP;
            cause <= 2'd3;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_MULDIV: begin
          if (muldivDone) st <= S_WB;
        end
        S_WB: begin
          st  <= S_FETCH;
          cnt <= 8'd0;
        end
        S_TRAP: begin
          if (!TRAP_HALT) begin
            st  <= S_FETCH;
            cnt <= 8'd0;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  // Strobes and handshakes follow the state; forced low while reset is asserted
  // so an aborted instruction never writes PC or registers.
  always_comb begin
    fetchReq    = rst_n && (st == S_FETCH);
    irWrite     = rst_n && (st == S_FETCH) && fetchAck;
    memRead     = rst_n && (st == S_MEM) && is_load;
    memWrite    = rst_n && (st == S_MEM) && is_store;
    muldivStart = rst_n && (st == S_MULDIV) && md_first;
    retired     = rst_n && (st == S_WB);
    regWrite    = rst_n && (st == S_WB) && !is_br && !is_store;
    pcWrite     = rst_n && ((st == S_WB) || ((st == S_TRAP) && !TRAP_HALT));
    trapValid   = (st == S_TRAP);
    trapCause   = cause;
    state       = st;
    jumpSel     = 2'd0;
    if (st == S_WB) begin
      if (is_jal)       jumpSel = 2'd1;
      else if (is_jalr) jumpSel = 2'd2;
      else if (is_br)   jumpSel = (aluFlag ^ func3[0]) ? 2'd1 : 2'd0;
    end
  end

  // Datapath decode from the latched fields, stable from DECODE through WB
  always_comb begin
    aluSelect  = 4'b0000;
    Alu2opn    = 2'd0;
    InstFormat = 3'd0;
    WL         = 2'd0;
    memtoReg   = 1'b0;
    pc4toReg   = 1'b0;
    pcImmtoReg = 1'b0;
    extendSign = 1'b0;
    case (opcode)
      OP_LUI: begin
        aluSelect  = 4'b1111;
        Alu2opn    = 2'd1;
        InstFormat = 3'd4;
      end
      OP_AUIPC: begin
        Alu2opn    = 2'd2;
        InstFormat = 3'd4;
        pcImmtoReg = 1'b1;
      end
      OP_JAL: begin
        InstFormat = 3'd5;
        pc4toReg   = 1'b1;
      end
      OP_JALR: begin
        Alu2opn    = 2'd1;
        InstFormat = 3'd1;
        pc4toReg   = 1'b1;
      end
      OP_BR: begin
        InstFormat = 3'd3;
        case (func3[2:1])
          2'b10:   aluSelect = 4'b0010;
          2'b11:   aluSelect = 4'b0011;
          default: aluSelect = 4'b1010;
        endcase
      end
      OP_LOAD: begin
        Alu2opn    = 2'd1;
        InstFormat = 3'd1;
        WL         = func3[1:0];
        extendSign = ~func3[2];
        memtoReg   = 1'b1;
      end
      OP_STORE: begin
        Alu2opn    = 2'd1;
        InstFormat = 3'd2;
        WL         = func3[1:0];
      end
      OP_IMM: begin
        Alu2opn    = 2'd1;
        InstFormat = 3'd1;
        aluSelect  = {1'b0, func3};
        if (func3 == 3'b101) aluSelect = func7[5] ? 4'b1101 : 4'b0101;
      end
      OP_R: begin
        aluSelect = {1'b0, func3};
        if (func7 != F7_M) begin
          if (func3 == 3'b000 && func7[5]) aluSelect = 4'b1000;
          if (func3 == 3'b101 && func7[5]) aluSelect = 4'b1101;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Instance "dut" has M enabled and
// resumes after traps; instance "alt" has M disabled and halts in TRAP.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n, fetchAck, memAck, aluFlag, muldivDone;
  logic [31:0] instr;

  logic       fetchReq, irWrite, pcWrite, regWrite, memRead, memWrite, muldivStart;
  logic       memtoReg, pc4toReg, pcImmtoReg, extendSign, retired, trapValid;
  logic [1:0] Alu2opn, jumpSel, WL, trapCause;
  logic [3:0] aluSelect;
  logic [2:0] InstFormat, state;

  logic       a_fetchReq, a_irWrite, a_pcWrite, a_regWrite, a_memRead, a_memWrite, a_muldivStart;
  logic       a_memtoReg, a_pc4toReg, a_pcImmtoReg, a_extendSign, a_retired, a_trapValid;
  logic [1:0] a_Alu2opn, a_jumpSel, a_WL, a_trapCause;
  logic [3:0] a_aluSelect;
  logic [2:0] a_InstFormat, a_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.ENABLE_M(1'b1), .MEM_TIMEOUT(15), .TRAP_HALT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .fetchReq(fetchReq), .fetchAck(fetchAck),
    .memAck(memAck), .aluFlag(aluFlag), .muldivDone(muldivDone), .irWrite(irWrite),
    .pcWrite(pcWrite), .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .muldivStart(muldivStart), .memtoReg(memtoReg), .pc4toReg(pc4toReg),
    .pcImmtoReg(pcImmtoReg), .extendSign(extendSign), .Alu2opn(Alu2opn),
    .jumpSel(jumpSel), .WL(WL), .aluSelect(aluSelect), .InstFormat(InstFormat),
    .retired(retired), .trapValid(trapValid), .trapCause(trapCause), .state(state));

  multicycle_controller #(.ENABLE_M(1'b0), .MEM_TIMEOUT(15), .TRAP_HALT(1'b1)) alt (
    .clk(clk), .rst_n(rst_n), .instr(instr), .fetchReq(a_fetchReq), .fetchAck(fetchAck),
    .memAck(memAck), .aluFlag(aluFlag), .muldivDone(muldivDone), .irWrite(a_irWrite),
    .pcWrite(a_pcWrite), .regWrite(a_regWrite), .memRead(a_memRead), .memWrite(a_memWrite),
    .muldivStart(a_muldivStart), .memtoReg(a_memtoReg), .pc4toReg(a_pc4toReg),
    .pcImmtoReg(a_pcImmtoReg), .extendSign(a_extendSign), .Alu2opn(a_Alu2opn),
    .jumpSel(a_jumpSel), .WL(a_WL), .aluSelect(a_aluSelect), .InstFormat(a_InstFormat),
    .retired(a_retired), .trapValid(a_trapValid), .trapCause(a_trapCause), .state(a_state));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int starts;
    rst_n = 1'b0; instr = 32'h0; fetchAck = 1'b0; memAck = 1'b0;
    aluFlag = 1'b0; muldivDone = 1'b0;
    step(); step();

    // Reset state: IDLE, no strobes, NOP decode (addi)
    chk("rst_state", state, 0);
    chk("rst_cause", trapCause, 0);
    chk("rst_fetchReq", fetchReq, 0);
    chk("rst_pcWrite", pcWrite, 0);
    chk("rst_alusel", aluSelect, 4'b0000);
    chk("rst_alu2", Alu2opn, 1);
    chk("rst_fmt", InstFormat, 1);

    // ADDI x1,x0,5 with immediate fetch ack
    rst_n = 1'b1;
    step();
    chk("addi_fetch", state, 1);
    chk("addi_req", fetchReq, 1);
    instr = 32'h00500093; fetchAck = 1'b1; #1;
    chk("addi_irw", irWrite, 1);
    step(); fetchAck = 1'b0;
    chk("addi_dec", state, 2);
    chk("addi_alusel", aluSelect, 4'b0000);
    chk("addi_alu2", Alu2opn, 1);
    chk("addi_fmt", InstFormat, 1);
    step();
    chk("addi_exec", state, 3);
    chk("addi_exec_rw", regWrite, 0);
    step();
    chk("addi_wb", state, 6);
    chk("addi_rw", regWrite, 1);
    chk("addi_pcw", pcWrite, 1);
    chk("addi_ret", retired, 1);
    chk("addi_js", jumpSel, 0);
    step();
    chk("addi_next", state, 1);

    // LH x1,0(x0), memAck delayed three cycles
    instr = 32'h00001083; fetchAck = 1'b1;
    step(); fetchAck = 1'b0;
    chk("lh_wl", WL, 1);
    chk("lh_ext", extendSign, 1);
    chk("lh_m2r", memtoReg, 1);
    step();
    step();
    chk("lh_mem", state, 4);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      memAck = (i == 3); #1;
      if (memRead) n++;
      if (i < 3) chk("lh_wait", state, 4);
      step();
    end
    memAck = 1'b0;
    chk("lh_rd_cycles", n, 4);
    chk("lh_wb", state, 6);
    chk("lh_rw", regWrite, 1);
    chk("lh_memrd_wb", memRead, 0);
    step();

    // BNE x0,x0,8: taken (aluFlag=0) then not taken (aluFlag=1) in WB
    instr = 32'h00001463; fetchAck = 1'b1;
    step(); fetchAck = 1'b0;
    chk("bne_alusel", aluSelect, 4'b1010);
    chk("bne_fmt", InstFormat, 3);
    step();
    step();
    chk("bne_wb", state, 6);
    aluFlag = 1'b0; #1;
    chk("bne_taken_js", jumpSel, 1);
    chk("bne_rw", regWrite, 0);
    chk("bne_pcw", pcWrite, 1);
    aluFlag = 1'b1; #1;
    chk("bne_nt_js", jumpSel, 0);
    step(); aluFlag = 1'b0;

    // MUL x1,x2,x3: dut runs mul/div, alt (no M) traps illegal and halts
    instr = 32'h023100B3; fetchAck = 1'b1;
    step(); fetchAck = 1'b0;
    chk("mul_dec", state, 2);
    step();
    chk("mul_state", state, 5);
    chk("mul_alt_trap", a_state, 7);
    chk("mul_alt_cause", a_trapCause, 1);
    chk("mul_alusel", aluSelect, 4'b0000);
    chk("mul_alu2", Alu2opn, 0);
    starts = 0;
    for (int i = 0; i < 7; i++) begin
      muldivDone = (i == 6); #1;
      if (muldivStart) starts++;
      if (i < 6) chk("mul_wait", state, 5);
      step();
    end
    muldivDone = 1'b0;
    chk("mul_starts", starts, 1);
    chk("mul_wb", state, 6);
    chk("mul_rw", regWrite, 1);
    chk("mul_alt_halt", a_state, 7);
    chk("mul_alt_tv", a_trapValid, 1);

    // Re-synchronise both instances
    rst_n = 1'b0;
    step();
    chk("rst2_state", state, 0);
    chk("rst2_alt", a_state, 0);
    chk("rst2_cause", trapCause, 0);
    rst_n = 1'b1;
    step();

    // Opcode 0000000: illegal, one-cycle trap with pcWrite and no retire
    instr = 32'h00000000; fetchAck = 1'b1;
    step(); fetchAck = 1'b0;
    step();
    chk("ill_trap", state, 7);
    chk("ill_tv", trapValid, 1);
    chk("ill_cause", trapCause, 1);
    chk("ill_pcw", pcWrite, 1);
    chk("ill_ret", retired, 0);
    chk("ill_js", jumpSel, 0);
    step();
    chk("ill_resume", state, 1);
    chk("ill_sticky", trapCause, 1);
    chk("ill_alt_halt", a_state, 7);

    // Fetch timeout: 15 FETCH cycles without ack
    for (int i = 0; i < 14; i++) begin
      chk("fto_wait", state, 1);
      step();
    end
    chk("fto_last", state, 1);
    step();
    chk("fto_trap", state, 7);
    chk("fto_cause", trapCause, 2);
    step();
    chk("fto_resume", state, 1);

    // Ack in the 15th FETCH cycle wins over the timeout
    for (int i = 0; i < 14; i++) step();
    instr = 32'h00500093; fetchAck = 1'b1;
    step(); fetchAck = 1'b0;
    chk("fack_dec", state, 2);
    chk("fack_cause", trapCause, 2);
    step(); step(); step();
    chk("fack_fetch", state, 1);

    // LW then reset asserted during MEM
    instr = 32'h00002083; fetchAck = 1'b1;
    step(); fetchAck = 1'b0;
    chk("lw_wl", WL, 2);
    step(); step();
    chk("lw_mem", state, 4);
    chk("lw_rd", memRead, 1);
    rst_n = 1'b0; #1;
    chk("lw_rst_rd", memRead, 0);
    chk("lw_rst_pcw", pcWrite, 0);
    step();
    chk("lw_rst_state", state, 0);
    chk("lw_rst_rd2", memRead, 0);
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
